// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX scheduler: state encoding, counter width
// and a small constant helper used to size the shared timer.
package uart_sched_pkg;

  localparam int FRAME_CNT_W = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_KICK      = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_GAP       = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_LOAD      = ST_LOAD,
    S_KICK      = ST_KICK,
    S_WAIT_BUSY = ST_WAIT_BUSY,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_DONE      = ST_DONE,
    S_GAP       = ST_GAP
  } sched_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// FIFO read side and UART_TX handshake bundle. The scheduler is the master:
// it drives the pop strobe and the byte/valid pair, and watches empty/busy.
interface uart_tx_scheduler_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_inc;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_data_valid;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  tx_busy,
    output fifo_rd_inc,
    output tx_data,
    output tx_data_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output tx_busy,
    input  fifo_rd_inc,
    input  tx_data,
    input  tx_data_valid
  );
endinterface

// File: rtl/uart_tx_scheduler_timer.sv
// tx_sched_timer: clearable/loadable up-counter with a terminal-count compare.
// One instance serves both the busy-rise timeout and the inter-frame gap.
module tx_sched_timer #(
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             inc,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_q;

  // Count register: clear beats load, load beats increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (ld)   cnt_q <= ld_val;
    else if (inc)  cnt_q <= cnt_q + 1'b1;
  end

  assign tc = (cnt_q == tc_val);
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: pops one byte at a time from the FIFO read side and hands
// it to UART_TX with a one-cycle valid, then follows tx_busy to completion.
// Optional inter-frame gap: define UART_TX_SCHED_GAP_EN (GAP_CYCLES >= 1).
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   sched_en,
  uart_tx_scheduler_if.master    bus,
  output logic                   frame_done,
  output logic                   timeout_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   idle
);
  // Wide enough for either terminal value.
  localparam int TMR_W = $clog2(max_int(BUSY_TIMEOUT, GAP_CYCLES)) + 1;

  sched_state_t          st_q, st_d;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                  timeout_q, timeout_d;
  logic                  load_data;
  logic                  tmr_clr, tmr_inc, tmr_tc;
  logic [TMR_W-1:0]      tc_val;

`ifdef UART_TX_SCHED_GAP_EN
  assign tc_val = (st_q == S_GAP) ? TMR_W'(GAP_CYCLES - 1) : TMR_W'(BUSY_TIMEOUT - 1);
`else
  assign tc_val = TMR_W'(BUSY_TIMEOUT - 1);
`endif

  tx_sched_timer #(.CNT_W(TMR_W)) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (tmr_clr),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (tmr_inc),
    .tc_val (tc_val),
    .tc     (tmr_tc)
  );

  // Next-state and timer control; strobes come straight from the state register.
  always_comb begin
    st_d      = st_q;
    load_data = 1'b0;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    timeout_d = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (sched_en && !bus.fifo_empty) begin
          load_data = 1'b1;
          st_d      = S_LOAD;
        end
      end
      // The pop is committed here, so a late empty flag is irrelevant.
      S_LOAD: st_d = S_KICK;
      S_KICK: begin
        tmr_clr = 1'b1;
        st_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          st_d = S_WAIT_DONE;
        end else if (tmr_tc) begin
          timeout_d = 1'b1;
          st_d      = S_IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) st_d = S_DONE;
      end
`ifdef UART_TX_SCHED_GAP_EN
      S_DONE: begin
        tmr_clr = 1'b1;
        st_d    = S_GAP;
      end
      S_GAP: begin
        if (tmr_tc) st_d = S_IDLE;
        else        tmr_inc = 1'b1;
      end
`else
      S_DONE: st_d = S_IDLE;
`endif
      default: st_d = S_IDLE;
    endcase
  end

  // State register, captured byte, completed-frame count and timeout pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st_q        <= S_IDLE;
      tx_data_q   <= '0;
      frame_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      timeout_q <= timeout_d;
      if (load_data)        tx_data_q   <= bus.fifo_rd_data;
      if (st_q == S_DONE)   frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign bus.fifo_rd_inc   = (st_q == S_LOAD);
  assign bus.tx_data_valid = (st_q == S_KICK);
  assign bus.tx_data       = tx_data_q;
  assign frame_done        = (st_q == S_DONE);
  assign timeout_err       = timeout_q;
  assign frame_cnt         = frame_cnt_q;
  assign idle              = (st_q == S_IDLE);
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a queue-based FIFO and a UART busy model drive
// the DUT; expected event cycles are computed from frame-level timing rules.
module tb_uart_tx_scheduler;
  localparam int DW = 8;
  localparam int BT = 16;
  localparam int GC = 2;
`ifdef UART_TX_SCHED_GAP_EN
  localparam int GAP = GC;
`else
  localparam int GAP = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        sched_en = 1'b0;
  logic        frame_done, timeout_err, idle;
  logic [15:0] frame_cnt;

  uart_tx_scheduler_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_scheduler #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GC)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .sched_en    (sched_en),
    .bus         (bus),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .frame_cnt   (frame_cnt),
    .idle        (idle)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [DW-1:0] fifo_q[$];
  int uart_d[$], uart_b[$];
  int busy_start = -1, busy_end = -1;
  int pop_cyc[$], vld_cyc[$], done_cyc[$], to_cyc[$];
  logic [DW-1:0] vld_dat[$];
  int overlap = 0;
  int exp_vld[$], exp_done[$], exp_to[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [DW-1:0] sc_dat[$];
  int sc_d[$], sc_b[$];

  function automatic void drive_fifo();
    bus.fifo_empty   = (fifo_q.size() == 0);
    bus.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endfunction

  function automatic void clear_mon();
    pop_cyc.delete(); vld_cyc.delete(); vld_dat.delete();
    done_cyc.delete(); to_cyc.delete(); overlap = 0;
  endfunction

  // One clock: record DUT events at the falling edge, then update FIFO/UART models.
  task automatic step();
    int d, b;
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    if (RST) begin
      if (bus.fifo_rd_inc) begin
        pop_cyc.push_back(cyc);
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      if (bus.tx_data_valid) begin
        vld_cyc.push_back(cyc);
        vld_dat.push_back(bus.tx_data);
        if (bus.tx_busy) overlap++;
        d = (uart_d.size() != 0) ? uart_d.pop_front() : 1;
        b = (uart_b.size() != 0) ? uart_b.pop_front() : 3;
        busy_start = (d == 0) ? -1 : cyc + d;
        busy_end   = (d == 0) ? -1 : cyc + d + b;
      end
      if (frame_done)  done_cyc.push_back(cyc);
      if (timeout_err) to_cyc.push_back(cyc);
    end else begin
      busy_start = -1;
      busy_end   = -1;
    end
    bus.tx_busy = (cyc >= busy_start) && (cyc < busy_end);
    drive_fifo();
  endtask

  task automatic load_scenario();
    uart_d.delete(); uart_b.delete();
    foreach (sc_dat[i]) begin
      fifo_q.push_back(sc_dat[i]);
      uart_d.push_back(sc_d[i]);
      uart_b.push_back(sc_b[i]);
    end
    drive_fifo();
  endtask

  // Frame-level reference: valid comes 2 cycles after the idle sample; a frame whose
  // busy rises D cycles after valid and lasts B cycles completes D+B+1 cycles after
  // valid; the next idle sample follows DONE (plus the gap); a missing busy ends
  // BT+1 cycles after valid and returns straight to idle.
  task automatic build_model(input int n);
    int t, dn;
    exp_vld.delete(); exp_done.delete(); exp_to.delete();
    t = n + 2;
    foreach (sc_dat[i]) begin
      exp_vld.push_back(t);
      if (sc_d[i] == 0) begin
        exp_to.push_back(t + 1 + BT);
        t = t + 1 + BT + 2;
      end else begin
        dn = t + sc_d[i] + sc_b[i] + 1;
        exp_done.push_back(dn);
        exp_cnt = exp_cnt + 16'd1;
        t = dn + 1 + GAP + 2;
      end
    end
  endtask

  task automatic run_frames(input int nev, input int budget, input string name);
    int k;
    k = 0;
    while ((done_cyc.size() + to_cyc.size()) < nev && k < budget) begin
      step();
      k++;
    end
    repeat (4) step();
    total++;
    if ((done_cyc.size() + to_cyc.size()) < nev) begin
      bad++;
      $display("FAIL %s_wait: events=%0d required=%0d", name, done_cyc.size() + to_cyc.size(), nev);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", idle); end
    total++; if (bus.fifo_rd_inc !== 1'b0) begin bad++; $display("FAIL rst_pop: got %b want 0", bus.fifo_rd_inc); end
    total++; if (bus.tx_data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.tx_data_valid); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", bus.tx_data); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", frame_done); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout_err); end
    total++; if (frame_cnt !== 16'h0000) begin bad++; $display("FAIL rst_cnt: got %h want 0000", frame_cnt); end
    RST = 1'b1;
    sched_en = 1'b1;
    clear_mon();
    repeat (4) step();
    total++; if (pop_cyc.size() !== 0) begin bad++; $display("FAIL empty_no_pop: got %0d want 0", pop_cyc.size()); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL empty_idle: got %b want 1", idle); end
  endtask

  task automatic test_single();
    int n;
    clear_mon();
    sc_dat = '{8'hA5}; sc_d = '{1}; sc_b = '{11};
    load_scenario();
    n = cyc;
    build_model(n);
    run_frames(1, 60, "single");
    total++; if (pop_cyc.size() !== 1) begin bad++; $display("FAIL single_npop: got %0d want 1", pop_cyc.size()); end
    if (pop_cyc.size() > 0) begin
      total++; if (pop_cyc[0] !== n + 1) begin bad++; $display("FAIL single_pop_cyc: got %0d want %0d", pop_cyc[0], n + 1); end
    end
    total++; if (vld_cyc.size() !== 1) begin bad++; $display("FAIL single_nvalid: got %0d want 1", vld_cyc.size()); end
    if (vld_cyc.size() > 0) begin
      total++; if (vld_cyc[0] !== n + 2) begin bad++; $display("FAIL single_valid_cyc: got %0d want %0d", vld_cyc[0], n + 2); end
      total++; if (vld_dat[0] !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", vld_dat[0]); end
    end
    total++; if (done_cyc.size() !== 1) begin bad++; $display("FAIL single_ndone: got %0d want 1", done_cyc.size()); end
    if (done_cyc.size() > 0) begin
      total++; if (done_cyc[0] !== exp_done[0]) begin bad++; $display("FAIL single_done_cyc: got %0d want %0d", done_cyc[0], exp_done[0]); end
    end
    total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL single_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
    total++; if (bus.tx_data !== 8'hA5) begin bad++; $display("FAIL single_hold: got %h want a5", bus.tx_data); end
  endtask

  task automatic test_burst();
    int n;
    clear_mon();
    sc_dat = '{8'h01, 8'h02, 8'h03};
    sc_d = '{1, 1, 1};
    sc_b = '{$urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8)};
    load_scenario();
    n = cyc;
    build_model(n);
    run_frames(3, 120, "burst");
    total++; if (vld_cyc.size() !== exp_vld.size()) begin bad++; $display("FAIL burst_nvalid: got %0d want %0d", vld_cyc.size(), exp_vld.size()); end
    foreach (exp_vld[i]) if (i < vld_cyc.size()) begin
      total++; if (vld_cyc[i] !== exp_vld[i]) begin bad++; $display("FAIL burst_valid_cyc[%0d]: got %0d want %0d", i, vld_cyc[i], exp_vld[i]); end
      total++; if (vld_dat[i] !== sc_dat[i]) begin bad++; $display("FAIL burst_data[%0d]: got %h want %h", i, vld_dat[i], sc_dat[i]); end
    end
    total++; if (done_cyc.size() !== exp_done.size()) begin bad++; $display("FAIL burst_ndone: got %0d want %0d", done_cyc.size(), exp_done.size()); end
    foreach (exp_done[i]) if (i < done_cyc.size()) begin
      total++; if (done_cyc[i] !== exp_done[i]) begin bad++; $display("FAIL burst_done_cyc[%0d]: got %0d want %0d", i, done_cyc[i], exp_done[i]); end
    end
    for (int i = 0; i < 2; i++) if (i + 1 < vld_cyc.size() && i < done_cyc.size()) begin
      total++; if (vld_cyc[i + 1] - done_cyc[i] !== 3 + GAP) begin bad++; $display("FAIL burst_spacing[%0d]: got %0d want %0d", i, vld_cyc[i + 1] - done_cyc[i], 3 + GAP); end
    end
    total++; if (pop_cyc.size() !== 3) begin bad++; $display("FAIL burst_npop: got %0d want 3", pop_cyc.size()); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL burst_overlap: got %0d want 0", overlap); end
    total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL burst_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_timeout();
    int n;
    logic [15:0] cnt_before;
    clear_mon();
    cnt_before = frame_cnt;
    sc_dat = '{8'h5C}; sc_d = '{0}; sc_b = '{0};
    load_scenario();
    n = cyc;
    build_model(n);
    run_frames(1, 60, "timeout");
    total++; if (to_cyc.size() !== 1) begin bad++; $display("FAIL to_count: got %0d want 1", to_cyc.size()); end
    if (to_cyc.size() > 0) begin
      total++; if (to_cyc[0] !== n + 3 + BT) begin bad++; $display("FAIL to_cyc: got %0d want %0d", to_cyc[0], n + 3 + BT); end
    end
    total++; if (done_cyc.size() !== 0) begin bad++; $display("FAIL to_no_done: got %0d want 0", done_cyc.size()); end
    total++; if (frame_cnt !== cnt_before) begin bad++; $display("FAIL to_cnt: got %0d want %0d", frame_cnt, cnt_before); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL to_idle: got %b want 1", idle); end
  endtask

  task automatic test_random();
    int n;
    clear_mon();
    sc_dat.delete(); sc_d.delete(); sc_b.delete();
    for (int i = 0; i < 6; i++) begin
      sc_dat.push_back(8'($urandom_range(0, 255)));
      sc_d.push_back(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4)));
      sc_b.push_back(int'($urandom_range(1, 10)));
    end
    load_scenario();
    n = cyc;
    build_model(n);
    run_frames(6, 300, "random");
    total++; if (vld_cyc.size() !== exp_vld.size()) begin bad++; $display("FAIL rand_nvalid: got %0d want %0d", vld_cyc.size(), exp_vld.size()); end
    foreach (exp_vld[i]) if (i < vld_cyc.size()) begin
      total++; if (vld_cyc[i] !== exp_vld[i]) begin bad++; $display("FAIL rand_valid_cyc[%0d]: got %0d want %0d", i, vld_cyc[i], exp_vld[i]); end
      total++; if (vld_dat[i] !== sc_dat[i]) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, vld_dat[i], sc_dat[i]); end
    end
    total++; if (done_cyc.size() !== exp_done.size()) begin bad++; $display("FAIL rand_ndone: got %0d want %0d", done_cyc.size(), exp_done.size()); end
    foreach (exp_done[i]) if (i < done_cyc.size()) begin
      total++; if (done_cyc[i] !== exp_done[i]) begin bad++; $display("FAIL rand_done_cyc[%0d]: got %0d want %0d", i, done_cyc[i], exp_done[i]); end
    end
    total++; if (to_cyc.size() !== exp_to.size()) begin bad++; $display("FAIL rand_nto: got %0d want %0d", to_cyc.size(), exp_to.size()); end
    foreach (exp_to[i]) if (i < to_cyc.size()) begin
      total++; if (to_cyc[i] !== exp_to[i]) begin bad++; $display("FAIL rand_to_cyc[%0d]: got %0d want %0d", i, to_cyc[i], exp_to[i]); end
    end
    total++; if (overlap !== 0) begin bad++; $display("FAIL rand_overlap: got %0d want 0", overlap); end
    total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL rand_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_enable_drop();
    int n;
    clear_mon();
    sc_dat = '{8'h11, 8'h22, 8'h33}; sc_d = '{1, 1, 1}; sc_b = '{6, 6, 6};
    load_scenario();
    n = cyc;
    while (cyc < n + 5) step();
    sched_en = 1'b0;
    repeat (30) step();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (pop_cyc.size() !== 1) begin bad++; $display("FAIL drop_npop: got %0d want 1", pop_cyc.size()); end
    total++; if (done_cyc.size() !== 1) begin bad++; $display("FAIL drop_ndone: got %0d want 1", done_cyc.size()); end
    if (done_cyc.size() > 0) begin
      total++; if (done_cyc[0] !== n + 10) begin bad++; $display("FAIL drop_done_cyc: got %0d want %0d", done_cyc[0], n + 10); end
    end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL drop_idle: got %b want 1", idle); end
    total++; if (fifo_q.size() !== 2) begin bad++; $display("FAIL drop_fifo_left: got %0d want 2", fifo_q.size()); end
    total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL drop_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    int n, n2, d1, d2, b1, b2;
    clear_mon();
    d1 = $urandom_range(1, 4); d2 = $urandom_range(1, 4);
    b1 = $urandom_range(1, 8); b2 = $urandom_range(1, 8);
    fifo_q.push_back(8'h44);
    drive_fifo();
    uart_d = '{1, d1, d2}; uart_b = '{8, b1, b2};
    sched_en = 1'b1;
    n = cyc;
    while (cyc < n + 5) step();
    RST = 1'b0;
    #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rmid_idle: got %b want 1", idle); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rmid_data: got %h want 00", bus.tx_data); end
    total++; if (frame_cnt !== 16'h0000) begin bad++; $display("FAIL rmid_cnt: got %h want 0000", frame_cnt); end
    total++; if ({bus.fifo_rd_inc, bus.tx_data_valid, frame_done, timeout_err} !== 4'b0000) begin
      bad++; $display("FAIL rmid_strobes: got %b want 0000", {bus.fifo_rd_inc, bus.tx_data_valid, frame_done, timeout_err});
    end
    exp_cnt = 16'd0;
    repeat (2) step();
    clear_mon();
    RST = 1'b1;
    n2 = cyc;
    sc_dat = '{8'h33, 8'h44}; sc_d = '{d1, d2}; sc_b = '{b1, b2};
    build_model(n2);
    run_frames(2, 100, "rmid");
    total++; if (vld_cyc.size() !== exp_vld.size()) begin bad++; $display("FAIL rmid_nvalid: got %0d want %0d", vld_cyc.size(), exp_vld.size()); end
    foreach (exp_vld[i]) if (i < vld_cyc.size()) begin
      total++; if (vld_cyc[i] !== exp_vld[i]) begin bad++; $display("FAIL rmid_valid_cyc[%0d]: got %0d want %0d", i, vld_cyc[i], exp_vld[i]); end
      total++; if (vld_dat[i] !== sc_dat[i]) begin bad++; $display("FAIL rmid_data[%0d]: got %h want %h", i, vld_dat[i], sc_dat[i]); end
    end
    total++; if (done_cyc.size() !== exp_done.size()) begin bad++; $display("FAIL rmid_ndone: got %0d want %0d", done_cyc.size(), exp_done.size()); end
    foreach (exp_done[i]) if (i < done_cyc.size()) begin
      total++; if (done_cyc[i] !== exp_done[i]) begin bad++; $display("FAIL rmid_done_cyc[%0d]: got %0d want %0d", i, done_cyc[i], exp_done[i]); end
    end
    total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL rmid_cnt_after: got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_wrap();
    int n;
    clear_mon();
    force dut.frame_cnt_q = 16'hFFFF;
    step();
    release dut.frame_cnt_q;
    step();
    total++; if (frame_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %h want ffff", frame_cnt); end
    exp_cnt = 16'hFFFF;
    sc_dat = '{8'($urandom_range(0, 255))}; sc_d = '{1}; sc_b = '{int'($urandom_range(1, 6))};
    load_scenario();
    n = cyc;
    build_model(n);
    run_frames(1, 60, "wrap");
    total++; if (done_cyc.size() !== 1) begin bad++; $display("FAIL wrap_ndone: got %0d want 1", done_cyc.size()); end
    total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL wrap_cnt: got %h want %h", frame_cnt, exp_cnt); end
  endtask

  initial begin
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = '0;
    bus.tx_busy      = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_timeout();
    test_random();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
